timer_arbiter: RTL and testbench

TIMER_ARBITER -- requirements
Module: timer_arbiter

---
 rtl/timer_arbiter.sv | 122 ++++++++++++
 tb/tb_timer_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one prescaled down-counter timer among NREQ requesters.
// The owner keeps the timer until its done pulse or a cancel, independent of later req changes.
module timer_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int M    = 10,
    parameter int PW   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   delay,
    input  logic                cancel,
    output logic [NREQ-1:0]     grant,
    output logic [NREQ-1:0]     done,
    output logic                busy,
    output logic [W-1:0]        count
);
    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [PW-1:0]     presc;
    logic [PTRW-1:0]   rr_ptr;
    logic [PTRW-1:0]   owner;
    logic [PTRW-1:0]   win;
    logic [PTRW:0]     idx;
    logic              found;
    logic [NREQ-1:0]   win_oh;
    logic [W-1:0]      dsel;
    logic [PTRW-1:0]   rr_nxt;
    logic              tick;

    // Scan requesters starting at rr_ptr; idx never exceeds 2*NREQ-2, so one subtraction wraps it.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr} + (PTRW+1)'(k);
            if (idx >= (PTRW+1)'(NREQ))
                idx = idx - (PTRW+1)'(NREQ);
            if (!found && req[idx[PTRW-1:0]]) begin
                found = 1'b1;
                win   = idx[PTRW-1:0];
            end
        end
    end

    assign win_oh = NREQ'(1) << win;
    assign dsel   = delay[int'(win)*W +: W];
    assign rr_nxt = (owner == PTRW'(NREQ-1)) ? '0 : owner + PTRW'(1);
    assign tick   = (presc == PW'(M-1));
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            done   <= '0;
            count  <= '0;
            presc  <= '0;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= '0;
                    presc <= '0;
                    if (found) begin
                        grant <= win_oh;
                        owner <= win;
                        count <= dsel;
                        if (dsel == '0) begin
                            state <= DONE;
                            done  <= win_oh;
                        end else begin
                            state <= RUN;
                        end
                    end else begin
                        grant <= '0;
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state  <= IDLE;
                        grant  <= '0;
                        count  <= '0;
                        presc  <= '0;
                        rr_ptr <= rr_nxt;
                    end else if (tick) begin
                        presc <= '0;
                        count <= count - W'(1);
                        // count is at least 1 while running, so this cannot underflow
                        if (count == W'(1)) begin
                            state <= DONE;
                            done  <= grant;
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done   <= '0;
                    grant  <= '0;
                    count  <= '0;
                    presc  <= '0;
                    rr_ptr <= rr_nxt;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    done  <= '0;
                    count <= '0;
                    presc <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter (NREQ=4, W=8, M=10): vector table plus corner-case sequences.
module tb_timer_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] delay;
    logic        cancel;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [7:0]  count;

    int checks = 0;
    int errors = 0;

    timer_arbiter #(.NREQ(4), .W(8), .M(10), .PW(4)) dut (
        .clk(clk), .reset(reset), .req(req), .delay(delay), .cancel(cancel),
        .grant(grant), .done(done), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] delay;   // {d3,d2,d1,d0}
        logic [3:0]  g;
        int          lat;     // cycles from first grant cycle to done
        logic [7:0]  d;       // delay of expected winner
    } vec_t;

    vec_t tab[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits at negedges for done; cyc = number of cycles waited.
    task automatic wait_done(input int maxc, output int cyc);
        cyc = 0;
        while (done == 4'b0 && cyc < maxc) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_count(input logic [7:0] v);
        int n = 0;
        while (count != v && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("count_reach", 32'(count), 32'(v));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [3:0] exp_g;
        reset = 1'b1; req = '0; delay = '0; cancel = 1'b0;

        tab[0] = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd3}, 4'b0001, 30, 8'd3};
        tab[1] = '{4'b0100, {8'd0, 8'd0, 8'd0, 8'd0}, 4'b0100,  0, 8'd0};
        tab[2] = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd2}, 4'b0001, 20, 8'd2};
        tab[3] = '{4'b1001, {8'd2, 8'd0, 8'd0, 8'd1}, 4'b1000, 20, 8'd2};
        tab[4] = '{4'b0110, {8'd0, 8'd1, 8'd4, 8'd0}, 4'b0010, 40, 8'd4};
        tab[5] = '{4'b0011, {8'd0, 8'd0, 8'd1, 8'd0}, 4'b0001,  0, 8'd0};

        #2;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_count", 32'(count), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_hold_grant", 32'(grant), 0);
        chk("idle_hold_busy",  32'(busy), 0);

        // Single transactions; rr_ptr carries from one entry to the next.
        for (int i = 0; i < 6; i++) begin
            req = tab[i].req; delay = tab[i].delay;
            @(negedge clk);
            chk($sformatf("v%0d_grant", i), 32'(grant), 32'(tab[i].g));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tab[i].d));
            req = '0;
            wait_done(200, cyc);
            chk($sformatf("v%0d_lat", i), cyc, tab[i].lat);
            chk($sformatf("v%0d_done", i), 32'(done), 32'(tab[i].g));
            chk($sformatf("v%0d_gdone", i), 32'(grant), 32'(tab[i].g));
            @(negedge clk);
            chk($sformatf("v%0d_done_off", i), 32'(done), 0);
            chk($sformatf("v%0d_busy_off", i), 32'(busy), 0);
            chk($sformatf("v%0d_grant_off", i), 32'(grant), 0);
        end

        // Round robin with all requesters held.
        do_reset();
        req = 4'b1111; delay = {8'd1, 8'd1, 8'd1, 8'd1};
        exp_g = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_grant", k), 32'(grant), 32'(exp_g));
            wait_done(50, cyc);
            chk($sformatf("rr%0d_lat", k), cyc, 10);
            chk($sformatf("rr%0d_done", k), 32'(done), 32'(exp_g));
            @(negedge clk);
            chk($sformatf("rr%0d_gap", k), 32'(grant), 0);
            exp_g = {exp_g[2:0], exp_g[3]};
        end
        req = '0;
        @(negedge clk);

        // Owner drops req one cycle after grant; timer keeps running.
        req = 4'b0001; delay = {8'd0, 8'd0, 8'd0, 8'd2};
        @(negedge clk);
        chk("drop_grant", 32'(grant), 32'h1);
        @(negedge clk);
        req = '0;
        cyc = 1;
        while (done == 4'b0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("drop_lat", cyc, 20);
        chk("drop_done", 32'(done), 32'h1);
        @(negedge clk);

        // Async reset mid-run at count=2.
        req = 4'b0001; delay = {8'd0, 8'd0, 8'd0, 8'd4};
        @(negedge clk);
        req = '0;
        wait_count(8'd2);
        #2 reset = 1'b1;
        #1;
        chk("arst_grant", 32'(grant), 0);
        chk("arst_done",  32'(done), 0);
        chk("arst_busy",  32'(busy), 0);
        chk("arst_count", 32'(count), 0);
        @(negedge clk);
        reset = 1'b0;
        req = 4'b1010; delay = {8'd1, 8'd1, 8'd1, 8'd1};
        @(negedge clk);
        chk("arst_regrant", 32'(grant), 32'h2);
        req = '0;
        wait_done(50, cyc);
        chk("arst_lat", cyc, 10);
        @(negedge clk);

        // Cancel at count=2: no done, next winner is requester 1.
        do_reset();
        req = 4'b0011; delay = {8'd0, 8'd0, 8'd1, 8'd5};
        @(negedge clk);
        chk("cxl_grant0", 32'(grant), 32'h1);
        wait_count(8'd2);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cxl_grant", 32'(grant), 0);
        chk("cxl_done",  32'(done), 0);
        chk("cxl_count", 32'(count), 0);
        chk("cxl_busy",  32'(busy), 0);
        @(negedge clk);
        chk("cxl_next",  32'(grant), 32'h2);
        req = '0;
        wait_done(50, cyc);
        chk("cxl_next_done", 32'(done), 32'h2);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
